// File: rtl/sub_pipe.sv
// Pipelined two's-complement subtractor (o = a - b) with one CHUNK-bit borrow slice per stage.
// Optional saturation on signed overflow when SUB_PIPE_SAT_EN is defined.
module sub_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             borrow,
   output logic             ovf
);

   localparam int unsigned STAGES = (WIDTH + CHUNK - 1) / CHUNK;

   logic [STAGES-1:0]            v_q, v_d, bw_q, bw_d, ld;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
   logic                         rdy_q;

   // A stage loads when empty or when its successor loads; the last stage looks at out_ready.
   always_comb begin
      ld = '0;
      ld[STAGES-1] = ~v_q[STAGES-1] | out_ready;
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
         ld[k] = ~v_q[k] | ld[k+1];
      end
   end

   assign in_ready = rdy_q & ld[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned Lo = k * CHUNK;
      localparam int unsigned Hi = (Lo + CHUNK > WIDTH) ? WIDTH - 1 : Lo + CHUNK - 1;
      localparam int unsigned Cw = Hi - Lo + 1;

      logic [WIDTH-1:0] src_a, src_b, src_r, nxt_r;
      logic             src_v, cin;
      logic [Cw:0]      sum;

      if (k == 0) begin : g_head
         assign src_a = a;
         assign src_b = b;
         assign src_r = '0;
         assign src_v = in_valid & in_ready;
         assign cin   = 1'b1;
      end else begin : g_body
         assign src_a = a_q[k-1];
         assign src_b = b_q[k-1];
         assign src_r = r_q[k-1];
         assign src_v = v_q[k-1];
         assign cin   = ~bw_q[k-1];
      end

      assign sum = {1'b0, src_a[Hi:Lo]} + {1'b0, ~src_b[Hi:Lo]} + {{Cw{1'b0}}, cin};

      always_comb begin
         nxt_r        = src_r;
         nxt_r[Hi:Lo] = sum[Cw-1:0];
      end

      // Borrow is stored inverted from carry so the cleared state reads as "no borrow".
      assign v_d[k]  = src_v;
      assign a_d[k]  = src_a;
      assign b_d[k]  = src_b;
      assign r_d[k]  = nxt_r;
      assign bw_d[k] = ~sum[Cw];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         v_q   <= '0;
         bw_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         r_q   <= '0;
      end else begin
         rdy_q <= 1'b1;
         for (int k = 0; k < int'(STAGES); k++) begin
            if (ld[k]) begin
               v_q[k]  <= v_d[k];
               bw_q[k] <= bw_d[k];
               a_q[k]  <= a_d[k];
               b_q[k]  <= b_d[k];
               r_q[k]  <= r_d[k];
            end
         end
      end
   end

   logic a_msb, b_msb, r_msb, unused_ops;

   assign a_msb      = a_q[STAGES-1][WIDTH-1];
   assign b_msb      = b_q[STAGES-1][WIDTH-1];
   assign r_msb      = r_q[STAGES-1][WIDTH-1];
   assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

   assign out_valid = v_q[STAGES-1];
   assign borrow    = bw_q[STAGES-1];
   assign ovf       = (a_msb ^ b_msb) & (r_msb ^ a_msb);

   always_comb begin
      o = r_q[STAGES-1];
`ifdef SUB_PIPE_SAT_EN
      if (ovf) begin
         o            = '0;
         o[WIDTH-1]   = 1'b1;
         if (!a_msb) o = ~o;
      end
`endif
   end

endmodule

// File: tb/tb_sub_pipe.sv
// Scoreboard bench for sub_pipe (WIDTH=32, CHUNK=8): directed steps, reference model queue.
module tb_sub_pipe;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, borrow, ovf;
   logic [31:0] a, b, o;

   typedef struct packed {
      logic [31:0] o;
      logic        bw;
      logic        ov;
   } exp_t;

   exp_t q[$];
   int   out_cyc[$];
   int   n_cmp = 0, n_err = 0, n_acc = 0, cyc = 0;

   sub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .borrow    (borrow),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(logic [31:0] x, logic [31:0] y);
      exp_t e;
      e.o  = x - y;
      e.bw = (x < y);
      e.ov = (x[31] != y[31]) && (e.o[31] != x[31]);
`ifdef SUB_PIPE_SAT_EN
      if (e.ov) e.o = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return e;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // One cycle: evaluate the transfers due at the coming edge, then move to the next negedge.
   task automatic tick();
      exp_t e;
      #1;
      if (in_valid && in_ready) begin
         q.push_back(model(a, b));
         n_acc++;
      end
      if (out_valid && out_ready) begin
         check("sb_nonempty", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("o", o, e.o);
            check("borrow", borrow, e.bw);
            check("ovf", ovf, e.ov);
         end
         out_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(logic [31:0] x, logic [31:0] y);
      a = x;
      b = y;
      in_valid = 1'b1;
      check("send_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(int limit);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < limit && q.size() != 0; i++) tick();
      check("drain_done", q.size(), 0);
   endtask

   initial begin
      int          base, acc0;
      logic        have;
      logic [31:0] held;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #2;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_o", o, 32'h0);
      check("rst_borrow", borrow, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("rel_in_ready_pre", in_ready, 1'b0);
      @(negedge clk);
      check("rel_in_ready_post", in_ready, 1'b1);

      // 1: latency and single-cycle output pulse
      out_ready = 1'b1;
      send(32'h5, 32'h3);
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("lat_%0d", i), out_valid, (i == 4));
         tick();
      end

      // 2/3: borrow through all chunks, signed overflow both ways
      send(32'h0000_0000, 32'h0000_0001);
      send(32'h0001_0000, 32'h0000_0001);
      send(32'h8000_0000, 32'h0000_0001);
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
      send(32'hFFFF_FFFF, 32'h0000_0000);
      drain(20);

      // 4: back-to-back random stream
      base = out_cyc.size();
      for (int i = 0; i < 16; i++) begin
         a = $urandom; b = $urandom; in_valid = 1'b1;
         check("b2b_in_ready", in_ready, 1'b1);
         tick();
      end
      drain(20);
      check("b2b_count", out_cyc.size() - base, 16);
      if (out_cyc.size() - base == 16) check("b2b_span", out_cyc[base+15] - out_cyc[base], 15);

      // 5: backpressure fills exactly STAGES entries, head held stable
      out_ready = 1'b0;
      acc0 = n_acc;
      have = 1'b0;
      held = '0;
      for (int i = 0; i < 7; i++) begin
         if (out_valid) begin
            if (!have) begin
               held = o;
               have = 1'b1;
            end else begin
               check("head_stable", o, held);
            end
         end
         a = $urandom; b = $urandom; in_valid = 1'b1;
         tick();
      end
      check("bp_accepted", n_acc - acc0, 4);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      #1 check("bp_in_ready_back", in_ready, 1'b1);
      tick();
      drain(20);

      // 6: asynchronous reset with ops in flight
      out_ready = 1'b0;
      send(32'h1111_1111, 32'h2);
      send(32'h3, 32'h4);
      send(32'h9, 32'h1);
      tick();
      tick();
      check("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_o", o, 32'h0);
      check("arst_borrow", borrow, 1'b0);
      check("arst_in_ready", in_ready, 1'b0);
      q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("arst_rel_ready", in_ready, 1'b0);
      @(negedge clk);
      check("arst_ready_up", in_ready, 1'b1);
      out_ready = 1'b1;
      send(32'h10, 32'h20);
      drain(10);
      for (int i = 0; i < 4; i++) begin
         check("no_ghost", out_valid, 1'b0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sub_pipe.md
Name: sub_pipe

Overview:
- Pipelined two's-complement subtractor, o = a - b, for WIDTH-bit operands.
- Complements the combinational add_bNN adder family: the datapath needs subtract and compare on a multi-cycle, back-pressurable path.
- Borrow ripples one CHUNK-bit slice per stage, so each stage's carry path is at most CHUNK bits long.
- Sits between operand producers and result consumers, which are joined by valid/ready handshakes.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 1.
- CHUNK, 8: bits resolved per pipeline stage; must satisfy 1 <= CHUNK <= WIDTH.
- STAGES, derived as ceil(WIDTH/CHUNK): pipeline depth; not overridable.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair on a/b is valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  result on o/borrow/ovf is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- o  out  WIDTH  difference a - b, modulo 2^WIDTH.
- borrow  out  1  unsigned borrow: 1 when a < b (unsigned).
- ovf  out  1  signed overflow of a - b.

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous, active-low.
  - Asserting rst_n clears every stage valid bit and every data register, asynchronously.
  - While reset is asserted: out_valid=0, o=0, borrow=0, ovf=0, in_ready=0.
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
  - Reset mid-operation drops all in-flight operations; none emerge after reset releases.
- Arithmetic: each stage k computes a[k-chunk] + ~b[k-chunk] + cin.
  - cin is 1 for stage 0; otherwise it is the carry-out of stage k-1, registered.
  - Carry-out of the top chunk = NOT borrow.
  - ovf = (a[MSB] != b[MSB]) && (o[MSB] != a[MSB]).
  - If WIDTH is not a multiple of CHUNK, the top chunk is WIDTH mod CHUNK bits wide.
- Skew: higher-chunk operand bits are delayed to meet their carry. Lower-chunk results are delayed so that all of o emerges together.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Stage i loads when it is empty or stage i+1 loads in the same cycle. The last stage uses out_ready in place of "stage i+1 loads".
  - in_ready = stage 0 can load this cycle. This is combinational from out_ready through the stage valid bits; a/b do not feed it.
- Latency and throughput:
  - An accepted pair presents out_valid exactly STAGES cycles after the accepting edge, given out_ready held high.
  - Throughput is one operation per cycle.
- Ordering: results leave in acceptance order.
  - No drop and no duplication under any valid/ready pattern.
  - Up to STAGES results are held under backpressure.
- Output stability: while out_valid=1 and out_ready=0, o/borrow/ovf are held stable.
- Pipeline bubbles: bubbles collapse. An empty stage accepts from upstream even while downstream is stalled.
- Simultaneous events: when the pipeline is full, an input accept and an output drain may occur in the same cycle (in_ready=1 when out_ready=1).

Optional Feature:
- Macro: SUB_PIPE_SAT_EN.
- Defined: on signed overflow, o saturates.
  - Positive overflow (a[MSB]=0) gives o = 2^(WIDTH-1)-1.
  - Negative overflow gives o = 2^(WIDTH-1).
  - ovf and borrow are still reported as in the unsaturated case.
  - Latency is unchanged: saturation is applied in the final stage.
- Undefined: o wraps modulo 2^WIDTH, and no saturation logic is present.

Test Plan:
All scenarios use WIDTH=32, CHUNK=8, STAGES=4.
1. a=0x00000005, b=0x00000003, out_ready=1 -> o=0x00000002, borrow=0, ovf=0; out_valid high exactly 4 cycles after accept, for 1 cycle.
2. a=0x00000000, b=0x00000001 -> o=0xFFFFFFFF, borrow=1, ovf=0 (borrow crosses all 4 chunks); a=0x00010000, b=0x00000001 -> o=0x0000FFFF, borrow=0.
3. a=0x80000000, b=0x00000001 -> ovf=1, borrow=0; o=0x7FFFFFFF without SUB_PIPE_SAT_EN, o=0x80000000 with it. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> ovf=1; o=0x80000000 (wrap) or 0x7FFFFFFF (saturated).
4. 16 back-to-back random pairs, in_valid=1, out_ready=1 -> 16 consecutive out_valid cycles matching a reference model in order; in_ready never drops.
5. Continuous input stream with out_ready=0 for 7 cycles -> exactly 4 ops accepted, then in_ready=0; head result stable throughout. On out_ready=1 all results drain in order with no loss/duplication, and in_ready returns in the same cycle.
6. rst_n asserted asynchronously (between edges) with 3 ops in flight -> out_valid=0, o=0, in_ready=0 immediately. After release, none of the 3 ops appear; a=0x10, b=0x20 then yields o=0xFFFFFFF0, borrow=1.
